// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: FSM encoding, default widths and the shared count/overflow arithmetic.
package perf_counter_pkg;
   localparam int NUM_CNT_DEF    = 4;
   localparam int CNT_WIDTH_DEF  = 32;
   localparam int STEP_WIDTH_DEF = 4;
   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
   typedef struct packed {
      logic [63:0] cnt;
      logic        ovf;
   } cnt_res_t;
   // Counts up to 64 bits wide; carry is taken at bit 'width'.
   function automatic cnt_res_t next_count(input logic [63:0] cnt, input logic [63:0] step,
                                           input logic sat, input int width);
      logic [64:0] sum;
      logic [63:0] ones;
      logic        carry;
      sum   = {1'b0, cnt} + {1'b0, step};
      ones  = {64{1'b1}} >> (64 - width);
      carry = sum[width];
      next_count.cnt = (sat && carry) ? ones : (sum[63:0] & ones);
      next_count.ovf = carry;
   endfunction
endpackage

// File: rtl/perf_counter_chan.sv
// perf_counter_chan: one live counter with sticky overflow and shadow copy.
// Threshold register and sticky irq exist only with PERF_CNT_THRESHOLD_IRQ_EN.
module perf_counter_chan
   import perf_counter_pkg::*;
#(
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int STEP_WIDTH = STEP_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   input  logic [STEP_WIDTH-1:0] step,
   input  logic                  sat,
   input  logic                  clr,
   input  logic                  snap,
`ifdef PERF_CNT_THRESHOLD_IRQ_EN
   input  logic                  thr_we,
   input  logic [CNT_WIDTH-1:0]  thr_data,
   output logic                  irq,
`endif
   output logic [CNT_WIDTH-1:0]  shadow,
   output logic                  ovf
);
   cnt_res_t             nxt;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, shadow_q;
   logic                 ovf_q, ovf_d;
   always_comb begin
      nxt   = next_count(64'(cnt_q), 64'(step), sat, CNT_WIDTH);
      cnt_d = clr ? '0 : inc ? CNT_WIDTH'(nxt.cnt) : cnt_q;
      ovf_d = !clr && (ovf_q || (inc && nxt.ovf));
   end
   // Shadow samples the pre-update value, so a coincident clear is not seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         shadow_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         if (snap) shadow_q <= cnt_q;
      end
   end
   assign shadow = shadow_q;
   assign ovf    = ovf_q;
`ifdef PERF_CNT_THRESHOLD_IRQ_EN
   logic [CNT_WIDTH-1:0] thr_q;
   logic                 irq_q, irq_d;
   always_comb irq_d = !clr && (irq_q || (cnt_q < thr_q && cnt_d >= thr_q));
   always_ff @(posedge clk) begin
      if (rst) begin
         thr_q <= '1;
         irq_q <= 1'b0;
      end else begin
         thr_q <= thr_we ? thr_data : thr_q;
         irq_q <= irq_d;
      end
   end
   assign irq = irq_q;
`endif
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: run/stop gated bank of counters with snapshot shadows and a 1-cycle read port.
// Optional threshold irq enabled by PERF_CNT_THRESHOLD_IRQ_EN.
module perf_counter_bank
   import perf_counter_pkg::*;
#(
   parameter int NUM_CNT    = NUM_CNT_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int STEP_WIDTH = STEP_WIDTH_DEF,
   parameter int IDX_WIDTH  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          stop,
   input  logic [NUM_CNT-1:0]            en,
   input  logic [NUM_CNT*STEP_WIDTH-1:0] step,
   input  logic [NUM_CNT-1:0]            sat_mode,
   input  logic [NUM_CNT-1:0]            clr,
   input  logic                          snap,
   input  logic                          rd_req,
   input  logic [IDX_WIDTH-1:0]          rd_idx,
`ifdef PERF_CNT_THRESHOLD_IRQ_EN
   input  logic                          thr_wr,
   input  logic [IDX_WIDTH-1:0]          thr_idx,
   input  logic [CNT_WIDTH-1:0]          thr_data,
   output logic [NUM_CNT-1:0]            irq,
`endif
   output logic                          rd_vld,
   output logic [CNT_WIDTH-1:0]          rd_data,
   output logic [NUM_CNT-1:0]            ovf,
   output logic                          running
);
   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] shadow [NUM_CNT];
   logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                 rd_vld_q;
   always_ff @(posedge clk) state_q <= rst ? ST_IDLE : state_d;
   always_comb state_d = stop ? ST_IDLE : start ? ST_RUN : state_q;
   always_comb running = (state_q == ST_RUN);
   for (genvar i = 0; i < NUM_CNT; i++) begin : g_chan
      perf_counter_chan #(.CNT_WIDTH(CNT_WIDTH), .STEP_WIDTH(STEP_WIDTH)) u_chan (
         .clk     (clk),
         .rst     (rst),
         .inc     (running && en[i]),
         .step    (step[i*STEP_WIDTH +: STEP_WIDTH]),
         .sat     (sat_mode[i]),
         .clr     (clr[i]),
         .snap    (snap),
`ifdef PERF_CNT_THRESHOLD_IRQ_EN
         .thr_we  (thr_wr && (32'(thr_idx) == i)),
         .thr_data(thr_data),
         .irq     (irq[i]),
`endif
         .shadow  (shadow[i]),
         .ovf     (ovf[i])
      );
   end
   always_comb rd_data_d = !rd_req ? rd_data_q : (32'(rd_idx) < NUM_CNT) ? shadow[rd_idx] : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_req;
      end
   end
   assign rd_data = rd_data_q;
   assign rd_vld  = rd_vld_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed and randomized checks against a spec-level model.
module tb_perf_counter_bank;
   localparam int N = 5, W = 8, SW = 4, IW = 3;
   localparam int MAXV = (1 << W) - 1;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, start, stop, snap, rd_req, rd_vld, running;
   logic [N-1:0] en, sat_mode, clr, ovf;
   logic [N*SW-1:0] step;
   logic [IW-1:0] rd_idx;
   logic [W-1:0] rd_data;
`ifdef PERF_CNT_THRESHOLD_IRQ_EN
   logic thr_wr;
   logic [IW-1:0] thr_idx;
   logic [W-1:0] thr_data;
   logic [N-1:0] irq;
`endif
   int cnt_m [N];
   int shad_m [N];
   logic [N-1:0] ovf_m;
   bit run_m, vld_m;
   int rdd_m;
   int checks = 0, errors = 0;

   perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(W), .STEP_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .step(step),
      .sat_mode(sat_mode), .clr(clr), .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx),
`ifdef PERF_CNT_THRESHOLD_IRQ_EN
      .thr_wr(thr_wr), .thr_idx(thr_idx), .thr_data(thr_data), .irq(irq),
`endif
      .rd_vld(rd_vld), .rd_data(rd_data), .ovf(ovf), .running(running)
   );

   task automatic idle_in();
      start = 0; stop = 0; snap = 0; rd_req = 0; rd_idx = '0;
      en = '0; sat_mode = '0; clr = '0; step = '0;
`ifdef PERF_CNT_THRESHOLD_IRQ_EN
      thr_wr = 0; thr_idx = '0; thr_data = '0;
`endif
   endtask

   // Advance one clock and apply the specified per-edge rules to the model.
   task automatic tick();
      int s;
      @(posedge clk);
      if (rst) begin
         foreach (cnt_m[i]) begin cnt_m[i] = 0; shad_m[i] = 0; end
         ovf_m = '0; run_m = 0; vld_m = 0; rdd_m = 0;
      end else begin
         vld_m = rd_req;
         if (rd_req) rdd_m = (int'(rd_idx) < N) ? shad_m[rd_idx] : 0;
         for (int i = 0; i < N; i++) begin
            if (snap) shad_m[i] = cnt_m[i];
            if (clr[i]) begin
               cnt_m[i] = 0; ovf_m[i] = 0;
            end else if (run_m && en[i]) begin
               s = cnt_m[i] + int'(step[i*SW +: SW]);
               if (s > MAXV) begin
                  ovf_m[i] = 1;
                  cnt_m[i] = sat_mode[i] ? MAXV : s - (MAXV + 1);
               end else cnt_m[i] = s;
            end
         end
         run_m = stop ? 0 : start ? 1 : run_m;
      end
      #1;
   endtask

   task automatic load(input int ch, input int val);
      int rem, s;
      clr[ch] = 1; tick(); clr[ch] = 0;
      en[ch] = 1; rem = val;
      while (rem > 0) begin
         s = rem > 15 ? 15 : rem;
         step[ch*SW +: SW] = SW'(s);
         tick();
         rem -= s;
      end
      en[ch] = 0;
   endtask

   task automatic peek(input int ch);
      snap = 1; tick(); snap = 0;
      rd_req = 1; rd_idx = IW'(ch); tick(); rd_req = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_in(); tick(); rst = 0;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
      checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld: got %b want 0", rd_vld); end
      checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
   endtask

   task automatic test_basic();
      start = 1; tick(); start = 0;
      en[0] = 1; step[0 +: SW] = 4'd3;
      repeat (5) tick();
      en[0] = 0;
      peek(0);
      checks++; if (rd_vld !== 1'b1) begin errors++; $display("FAIL basic_rd_vld: got %b want 1", rd_vld); end
      checks++; if (rd_data !== 8'd15) begin errors++; $display("FAIL basic_rd_data: got %0d want 15", rd_data); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL basic_running: got %b want 1", running); end
   endtask

   task automatic test_wrap_sat();
      load(2, 254);
      en[2] = 1; step[2*SW +: SW] = 4'd3; tick(); en[2] = 0;
      checks++; if (ovf[2] !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got %b want 1", ovf[2]); end
      peek(2);
      checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL wrap_value: got %h want 01", rd_data); end
      sat_mode[3] = 1;
      load(3, 254);
      checks++; if (ovf[3] !== 1'b0) begin errors++; $display("FAIL sat_pre_ovf: got %b want 0", ovf[3]); end
      en[3] = 1; step[3*SW +: SW] = 4'd3; tick(); en[3] = 0;
      checks++; if (ovf[3] !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", ovf[3]); end
      peek(3);
      checks++; if (rd_data !== 8'hFF) begin errors++; $display("FAIL sat_value: got %h want ff", rd_data); end
      en[3] = 1; step[3*SW +: SW] = 4'd1; tick(); en[3] = 0;
      peek(3);
      checks++; if (rd_data !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h want ff", rd_data); end
      checks++; if (ovf[3] !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", ovf[3]); end
      sat_mode[3] = 0;
   endtask

   task automatic test_clr_snap();
      load(1, 10);
      clr[1] = 1; en[1] = 1; step[1*SW +: SW] = 4'd5; snap = 1; tick();
      clr[1] = 0; en[1] = 0; snap = 0;
      checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL clrsnap_ovf: got %b want 0", ovf[1]); end
      rd_req = 1; rd_idx = 3'd1; tick(); rd_req = 0;
      checks++; if (rd_data !== 8'd10) begin errors++; $display("FAIL clrsnap_shadow: got %0d want 10", rd_data); end
      peek(1);
      checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL clrsnap_live: got %0d want 0", rd_data); end
      clr[2] = 1; tick(); clr[2] = 0;
      checks++; if (ovf[2] !== 1'b0) begin errors++; $display("FAIL clr_idle_ovf: got %b want 0", ovf[2]); end
   endtask

   task automatic test_fsm();
      stop = 1; tick(); stop = 0;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL fsm_stop: got %b want 0", running); end
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL fsm_start_stop: got %b want 0", running); end
      start = 1; tick(); start = 0;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL fsm_start: got %b want 1", running); end
      load(0, 20);
      en[0] = 1; step[0 +: SW] = 4'd2; stop = 1; tick(); stop = 0;
      repeat (3) tick();
      peek(0);
      checks++; if (rd_data !== 8'd22) begin errors++; $display("FAIL fsm_frozen: got %0d want 22", rd_data); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL fsm_idle: got %b want 0", running); end
      start = 1; tick(); start = 0;
      tick();
      en[0] = 0;
      peek(0);
      checks++; if (rd_data !== 8'd24) begin errors++; $display("FAIL fsm_resume: got %0d want 24", rd_data); end
   endtask

   task automatic test_back_to_back();
      int exp_v [4];
      int idx [4] = '{0, 1, 2, 7};
      int old;
      snap = 1; tick(); snap = 0;
      for (int k = 0; k < 4; k++) exp_v[k] = (idx[k] < N) ? shad_m[idx[k]] : 0;
      for (int k = 0; k < 4; k++) begin
         rd_req = 1; rd_idx = IW'(idx[k]); tick();
         checks++; if (rd_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld%0d: got %b want 1", k, rd_vld); end
         checks++; if (rd_data !== W'(exp_v[k])) begin errors++; $display("FAIL b2b_data%0d: got %0d want %0d", k, rd_data, exp_v[k]); end
      end
      rd_req = 0; tick();
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL b2b_vld_drop: got %b want 0", rd_vld); end
      old = shad_m[0];
      en[0] = 1; step[0 +: SW] = 4'd7; tick(); en[0] = 0;
      snap = 1; rd_req = 1; rd_idx = 3'd0; tick(); snap = 0;
      checks++; if (rd_data !== W'(old)) begin errors++; $display("FAIL snap_read_old: got %0d want %0d", rd_data, old); end
      tick(); rd_req = 0;
      checks++; if (rd_data !== W'((old + 7) % (MAXV + 1))) begin errors++; $display("FAIL snap_read_new: got %0d want %0d", rd_data, (old + 7) % (MAXV + 1)); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 9) == 0);
         stop = ($urandom_range(0, 14) == 0);
         en = N'($urandom);
         step = (N*SW)'($urandom);
         sat_mode = N'($urandom);
         for (int i = 0; i < N; i++) clr[i] = ($urandom_range(0, 19) == 0);
         snap = ($urandom_range(0, 3) == 0);
         rd_req = $urandom_range(0, 1);
         rd_idx = IW'($urandom);
         tick();
         checks++; if (running !== run_m) begin errors++; $display("FAIL rnd_running@%0d: got %b want %b", c, running, run_m); end
         checks++; if (ovf !== ovf_m) begin errors++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, ovf, ovf_m); end
         checks++; if (rd_vld !== vld_m) begin errors++; $display("FAIL rnd_rd_vld@%0d: got %b want %b", c, rd_vld, vld_m); end
         checks++; if (rd_data !== W'(rdd_m)) begin errors++; $display("FAIL rnd_rd_data@%0d: got %0d want %0d", c, rd_data, rdd_m); end
      end
      rst = 0; idle_in();
   endtask

   task automatic test_rst_mid_run();
      rst = 1; tick(); rst = 0;
      start = 1; tick(); start = 0;
      load(4, 250);
      en[4] = 1; step[4*SW +: SW] = 4'd15; tick();
      peek(4);
      checks++; if (ovf[4] !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL rst_pre: got ovf=%b run=%b want 1 1", ovf[4], running); end
      rst = 1; start = 1; snap = 1; rd_req = 1; tick(); rst = 0; start = 0; snap = 0; rd_req = 0; en = '0;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b want 0", running); end
      checks++; if (ovf !== '0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
      checks++; if (rd_vld !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL rst_rd: got vld=%b data=%0d want 0 0", rd_vld, rd_data); end
      peek(4);
      checks++; if (rd_data !== '0) begin errors++; $display("FAIL rst_counter: got %0d want 0", rd_data); end
   endtask

`ifdef PERF_CNT_THRESHOLD_IRQ_EN
   task automatic test_irq();
      rst = 1; tick(); rst = 0;
      start = 1; thr_wr = 1; thr_idx = 3'd0; thr_data = 8'd4; tick(); start = 0; thr_wr = 0;
      en[0] = 1; step[0 +: SW] = 4'd1;
      repeat (3) tick();
      checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq[0]); end
      tick();
      checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq[0]); end
      en[0] = 0; clr[0] = 1; tick(); clr[0] = 0;
      checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq[0]); end
   endtask
`endif

   initial begin
      rst = 1; idle_in();
      test_reset();
      test_basic();
      test_wrap_sat();
      test_clr_snap();
      test_fsm();
      test_back_to_back();
      test_random();
      test_rst_mid_run();
`ifdef PERF_CNT_THRESHOLD_IRQ_EN
      test_irq();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Bank of NUM_CNT independent performance counters. Each channel has its own variable step, a wrap or saturate mode, a sticky overflow flag, and a per-channel clear. A global run/stop FSM gates counting. A snapshot copies all counters atomically into shadow registers. Shadows are read through a 1-cycle-latency indexed read port. The block sits beside the accelerator datapath and collects cycle, stall and transaction statistics for the host CSR layer.

Parameters:
- NUM_CNT, 4: number of counter channels (1..32).
- CNT_WIDTH, 32: bits per counter.
- STEP_WIDTH, 4: bits per per-channel step input.
- IDX_WIDTH, $clog2(NUM_CNT) (min 1): read index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- start  in  1  pulse: IDLE->RUN.
- stop  in  1  pulse: RUN->IDLE.
- en  in  NUM_CNT  per-channel count enable.
- step  in  NUM_CNT*STEP_WIDTH  per-channel increment; channel i uses bits [i*STEP_WIDTH +: STEP_WIDTH].
- sat_mode  in  NUM_CNT  1 = saturate, 0 = wrap; per channel, sampled every cycle.
- clr  in  NUM_CNT  per-channel clear of the live counter and its overflow flag.
- snap  in  1  capture all live counters into shadows.
- rd_req  in  1  read request.
- rd_idx  in  IDX_WIDTH  shadow index to read.
- rd_vld  out  1  read data valid.
- rd_data  out  CNT_WIDTH  shadow value.
- ovf  out  NUM_CNT  sticky overflow flags.
- running  out  1  FSM is in RUN.

Behaviour:
- FSM states are IDLE and RUN. Reset state is IDLE.
  - IDLE->RUN on start.
  - RUN->IDLE on stop.
  - If start and stop are asserted in the same cycle, stop wins: state goes to or stays in IDLE.
  - running = (state==RUN), registered.
- Channel i increments only when state==RUN and en[i]==1. The increment is step_i zero-extended. step_i==0 leaves the counter unchanged.
- Arithmetic: sum = {1'b0,cnt_i} + step_i, computed at CNT_WIDTH+1 bits. carry = sum[CNT_WIDTH].
  - Wrap mode: cnt_i <= sum[CNT_WIDTH-1:0]; ovf[i] <= 1 if carry.
  - Saturate mode: if carry, cnt_i <= all-ones and ovf[i] <= 1; otherwise cnt_i <= sum. A counter already at all-ones with step>0 stays at all-ones and sets ovf.
- ovf is sticky. It is cleared only by rst or clr[i].
- clr[i] wins over an increment in the same cycle: cnt_i <= 0 and ovf[i] <= 0. clr works in both IDLE and RUN.
- snap: all shadow_i <= cnt_i (the pre-update register value) on the same edge, for every channel at once. snap works in both states.
  - If clr[i] and snap coincide, shadow_i gets the pre-clear value.
- Read: on an edge where rd_req==1, rd_data <= shadow[rd_idx] and rd_vld <= 1. Otherwise rd_vld <= 0 and rd_data holds its value.
  - Latency is 1 cycle. Back-to-back reads give one result per cycle.
  - If rd_idx >= NUM_CNT, rd_data <= 0 and rd_vld <= 1.
  - A read in the same cycle as snap returns the old shadow value.
- Reset (rst, any time, including mid-RUN): all counters, shadows, ovf, rd_data, rd_vld and running go to 0, and state goes to IDLE. Inputs are ignored on the reset cycle.
- Counter updates become visible one cycle after the enabling edge. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro PERF_CNT_THRESHOLD_IRQ_EN.
- Defined:
  - Adds inputs thr_wr (1), thr_idx (IDX_WIDTH), thr_data (CNT_WIDTH).
  - Adds output irq (NUM_CNT).
  - Adds per-channel threshold registers, reset value all-ones.
  - A thr_wr pulse writes thr_data to threshold[thr_idx]; out-of-range indices are ignored.
  - irq[i] is sticky. It is set on the edge where cnt_i transitions from < threshold_i to >= threshold_i.
  - irq[i] is cleared by clr[i] or rst.
- Undefined: none of these ports or registers exist, and the behaviour above is unchanged.

Decomposition:
- Package perf_counter_pkg holds:
  - FSM state encoding (ST_IDLE=1'b0, ST_RUN=1'b1);
  - the default width constants;
  - a function computing the next count value and overflow from (cnt, step, sat).
- One sub-module, perf_counter_chan, covers a single channel: live counter, ovf, shadow, and optional threshold/irq. It is instantiated NUM_CNT times with a generate loop.
- The top level keeps the FSM, the read mux and the read register.

Test Plan:
- Reset, start, en[0]=1, step0=3 for 5 cycles, snap, read idx 0 -> rd_vld the next cycle, rd_data=15, running=1.
- CNT_WIDTH=8 wrap: cnt=0xFE, step=3 -> cnt=0x01, ovf[0]=1. Saturate: cnt=0xFE, step=3 -> cnt=0xFF, ovf=1; a further step=1 keeps 0xFF.
- Same cycle clr[1]+en[1]+snap with cnt1=10 -> cnt1=0, ovf[1]=0, shadow1=10.
- start+stop in the same cycle from IDLE -> stays IDLE; stop mid-run with en held -> counts frozen; start resumes from the frozen value.
- Reads in consecutive cycles, idx 0,1,2,7 with NUM_CNT=4 -> four consecutive rd_vld cycles, the last with rd_data=0. A read in the same cycle as snap returns the previous shadow.
- rst asserted mid-RUN with nonzero counts and ovf set -> all outputs 0 and IDLE on the next cycle. With PERF_CNT_THRESHOLD_IRQ_EN: threshold0=4, step=1 -> irq[0] rises on the edge cnt0 becomes 4.
